// File: rtl/key_sequencer_if.sv
// ---------------------------------------------------------------------------
// key_sequencer_if
//
// Command handshake between a command source (testbench, on-board
// controller or UART bridge) and the key_sequencer.
//
// Signals:
//   cmd_valid  source -> sequencer  a command is present on cmd_key
//   cmd_key    source -> sequencer  index (0..3) of the KEY line to pulse
//   cmd_ready  sequencer -> source  command buffer has room; a command is
//                                   taken on any posedge where
//                                   cmd_valid & cmd_ready
//
// Modports:
//   master  the command source
//   slave   the key_sequencer
// ---------------------------------------------------------------------------
interface key_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd_key;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_key,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        output cmd_ready
    );
endinterface

// File: rtl/key_sequencer.sv
// ---------------------------------------------------------------------------
// key_sequencer
//
// Scripted push-button generator. Commands naming a KEY line (0..3) are
// buffered in a small in-order FIFO and replayed one at a time as an
// active-low press of PRESS_CYCLES clocks followed by GAP_CYCLES clocks with
// every line released. Receivers built on the usual 3-flop key
// synchronisers see exactly one release event per command. HEX0 shows the
// index of the most recently released key.
//
// Parameters:
//   PRESS_CYCLES  clocks a KEY line is held low per press (>= 3)
//   GAP_CYCLES    clocks all lines stay high after each release (>= 3)
//   FIFO_DEPTH    command buffer entries (power of 2, >= 2)
//   CNT_W         width of the press/gap down-counter; must hold
//                 max(PRESS_CYCLES, GAP_CYCLES)
//
// Ports:
//   CLOCK_50  in   system clock, all logic on posedge
//   reset     in   asynchronous active-high reset, clears all state
//   cmd       if   command handshake (slave side): cmd_valid, cmd_key in,
//                  cmd_ready out (FIFO not full)
//   KEY       out  active-low button lines, idle 4'b1111
//   busy      out  press/gap in progress or FIFO non-empty
//   pending   out  FIFO occupancy, not counting the key being pulsed
//   HEX0      out  active-low seven-segment digit of the last released key
// ---------------------------------------------------------------------------
module key_sequencer #(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    key_sequencer_if.slave              cmd,
    output logic [3:0]                  KEY,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic [6:0]                  HEX0
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0]    FULL_COUNT = PW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       KEY_IDLE   = 4'b1111;
    localparam logic [6:0]       HEX_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       active_key;

    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [1:0]       head_key;

    // Seven-segment pattern (active-low, segment g in bit 6) for a key index.
    function automatic logic [6:0] seg(input logic [1:0] k);
        logic [6:0] pattern;
        pattern = HEX_BLANK;
        case (k)
            2'd0: pattern = 7'b1000000;
            2'd1: pattern = 7'b1111001;
            2'd2: pattern = 7'b0100100;
            2'd3: pattern = 7'b0110000;
            default: pattern = HEX_BLANK;
        endcase
        return pattern;
    endfunction

    // Handshake and status decode. cmd_ready looks only at the occupancy
    // registered before the edge, so a full buffer refuses a command even in
    // a cycle where it also hands one to the FSM; nothing is ever overwritten.
    assign fifo_empty    = (pending == '0);
    assign cmd.cmd_ready = (pending != FULL_COUNT);
    assign busy          = (state != IDLE) || !fifo_empty;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head_key      = fifo_mem[rd_ptr];

    // The FSM takes the head of the FIFO either straight from IDLE or on the
    // final GAP edge, which gives back-to-back presses with no idle cycle in
    // between. A command written at this same edge is not yet visible here,
    // which is what sets the one-cycle latency from acceptance to press.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            GAP:     pop = !fifo_empty && (count == '0);
            default: pop = 1'b0;
        endcase
    end

    // Command FIFO: a power-of-two ring so the pointers wrap on their own.
    // Occupancy is tracked separately so full and empty are unambiguous;
    // a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= cmd.cmd_key;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Press sequencer. KEY only changes on the edge that enters PRESS and the
    // edge that leaves it, so at most one line is ever low and the GAP phase
    // is guaranteed all-high. The counter is loaded with length-1 and the
    // phase ends on the edge where it is already zero, giving exactly
    // PRESS_CYCLES low cycles and GAP_CYCLES high cycles. Reset forces every
    // line high at once; a receiver sees that as one release, which is
    // accepted.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            active_key <= '0;
            KEY        <= KEY_IDLE;
            HEX0       <= HEX_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        active_key <= head_key;
                        KEY        <= ~(4'b0001 << head_key);
                        count      <= PRESS_LOAD;
                        state      <= PRESS;
                    end
                end
                PRESS: begin
                    if (count == '0) begin
                        KEY   <= KEY_IDLE;
                        HEX0  <= seg(active_key);
                        count <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        if (pop) begin
                            active_key <= head_key;
                            KEY        <= ~(4'b0001 << head_key);
                            count      <= PRESS_LOAD;
                            state      <= PRESS;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    KEY   <= KEY_IDLE;
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
